hazard_sequencer: RTL

- Central pipeline controller for the 5-stage RV32 core; sits beside the ID stage.
- Detects load-use hazards and inserts one bubble into ID/EX.
- Flushes IF/ID and ID/EX when a branch or jump is taken in EX.
- Freezes the whole pipeline while data memory is not ready, defers any redirect that arrives during the freeze, and keeps saturating stall/flush performance counters.

---
 rtl/hazard_sequencer_pkg.sv | 54 +++++
 rtl/hazard_sequencer_sat.sv | 23 ++
 rtl/hazard_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM encoding and the bundled
// control word that drives the PC, IF/ID and downstream pipeline enables.
package hazard_sequencer_pkg;

    typedef enum logic [1:0] {
        HS_RUN,
        HS_MEM_WAIT,
        HS_REDIRECT_PEND
    } hs_state_t;

    typedef struct packed {
        logic pc_write;
        logic pc_sel;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_freeze;
    } hazard_ctrl_t;

    function automatic hazard_ctrl_t ctrl_run();
        hazard_ctrl_t c;
        c             = '0;
        c.pc_write    = 1'b1;
        c.ifid_write  = 1'b1;
        return c;
    endfunction

    function automatic hazard_ctrl_t ctrl_freeze();
        hazard_ctrl_t c;
        c             = '0;
        c.pipe_freeze = 1'b1;
        return c;
    endfunction

    // IF/ID is left enabled so the flush to NOP actually lands in the register.
    function automatic hazard_ctrl_t ctrl_redirect();
        hazard_ctrl_t c;
        c             = '0;
        c.pc_write    = 1'b1;
        c.pc_sel      = 1'b1;
        c.ifid_write  = 1'b1;
        c.ifid_flush  = 1'b1;
        c.idex_bubble = 1'b1;
        return c;
    endfunction

    function automatic hazard_ctrl_t ctrl_load_use();
        hazard_ctrl_t c;
        c             = '0;
        c.idex_bubble = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_sequencer_sat.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: load-use bubbles, EX redirects, memory-wait freeze
// with deferred redirect, wait timeout and saturating stall/flush counters.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int RF_ADDRESS  = 5,
    parameter int PC_W        = 9,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  idex_memread,
    input  logic [RF_ADDRESS-1:0] idex_rd,
    input  logic [RF_ADDRESS-1:0] ifid_rs1,
    input  logic [RF_ADDRESS-1:0] ifid_rs2,
    input  logic                  ex_redirect,
    input  logic [PC_W-1:0]       ex_target,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  pc_sel,
    output logic [PC_W-1:0]       pc_target,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  pipe_freeze,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

    hs_state_t         state_reg, state_next;
    logic [PC_W-1:0]   pend_target_reg, pend_target_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              mem_err_reg, mem_err_next;

    hazard_ctrl_t      ctrl;
    logic [PC_W-1:0]   target;
    logic              load_use;
    logic              hold;
    logic              timed_out;
    logic              stall_inc;
    logic              flush_inc;

    assign load_use  = idex_memread && (idex_rd != '0) &&
                       ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    assign timed_out = (wait_cnt_reg == WAIT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= HS_RUN;
            pend_target_reg <= '0;
            wait_cnt_reg    <= '0;
            mem_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pend_target_reg <= pend_target_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_err_reg     <= mem_err_next;
        end
    end

    // In RUN only a fresh unready access freezes; in the wait states the freeze
    // persists until ready or until the wait counter hits the timeout.
    always_comb begin
        hold = 1'b0;
        case (state_reg)
            HS_RUN:           hold = dmem_req && !dmem_ready;
            HS_MEM_WAIT,
            HS_REDIRECT_PEND: hold = !dmem_ready && !timed_out;
            default:          hold = 1'b0;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        pend_target_next = pend_target_reg;
        wait_cnt_next    = wait_cnt_reg;
        mem_err_next     = mem_err_reg;
        ctrl             = ctrl_run();
        target           = '0;
        stall_inc        = 1'b0;
        flush_inc        = 1'b0;

        if (hold) begin
            ctrl          = ctrl_freeze();
            stall_inc     = 1'b1;
            wait_cnt_next = wait_cnt_reg + 1'b1;
            if (wait_cnt_reg == WAIT_LAST) begin
                mem_err_next = 1'b1;
            end
            // The first redirect seen while frozen belongs to the held EX
            // instruction; later ones must not overwrite it.
            if (ex_redirect && (state_reg != HS_REDIRECT_PEND)) begin
                pend_target_next = ex_target;
                state_next       = HS_REDIRECT_PEND;
            end else if (state_reg == HS_RUN) begin
                state_next = HS_MEM_WAIT;
            end
        end else begin
            state_next    = HS_RUN;
            wait_cnt_next = '0;
            if (state_reg == HS_REDIRECT_PEND) begin
                ctrl             = ctrl_redirect();
                target           = pend_target_reg;
                flush_inc        = 1'b1;
                pend_target_next = '0;
            end else if (ex_redirect) begin
                ctrl      = ctrl_redirect();
                target    = ex_target;
                flush_inc = 1'b1;
            end else if (load_use) begin
                ctrl      = ctrl_load_use();
                stall_inc = 1'b1;
            end
        end

        if (!reset) begin
            ctrl   = ctrl_run();
            target = '0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign pc_write    = ctrl.pc_write;
    assign pc_sel      = ctrl.pc_sel;
    assign pc_target   = target;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign pipe_freeze = ctrl.pipe_freeze;
    assign mem_err     = mem_err_reg;

endmodule
